// File: rtl/mw_dmem_sequencer.sv
// MW-stage data-memory sequencer: valid/ready request, response wait, store alignment, load extension.
// Optional macro MW_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of rounding down.
module mw_dmem_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_re,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-3:0] dmem_req_addr,
  output logic [3:0]        dmem_req_wmask,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        re_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [1:0]  off;
  logic [3:0]  mask_c;
  logic [DATA_W-1:0] wdata_c;
  logic        trap_c;
  logic        accept_c;

  assign off      = req_addr[1:0];
  assign accept_c = (state_q == S_IDLE) && req_valid;

  // Lane alignment of the store mask and data; loads never write
  always_comb begin
    mask_c  = 4'b0000;
    wdata_c = req_wdata;
    case (req_funct3)
      3'b000: begin
        mask_c  = 4'b0001 << off;
        wdata_c = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        mask_c  = 4'b0011 << {off[1], 1'b0};
        wdata_c = {2{req_wdata[15:0]}};
      end
      3'b010:  mask_c = 4'b1111;
      default: mask_c = 4'b0000;
    endcase
    if (req_re) mask_c = 4'b0000;
  end

`ifdef MW_MISALIGN_TRAP_EN
  always_comb begin
    trap_c = 1'b0;
    if (req_funct3 == 3'b010)
      trap_c = (off != 2'b00);
    else if ((req_funct3 == 3'b001) || (req_re && (req_funct3 == 3'b101)))
      trap_c = off[0];
  end
`else
  assign trap_c = 1'b0;
`endif

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      3'b010:  load_ext = w;
      default: load_ext = 32'd0;
    endcase
  endfunction

  // Next state and the combinational stall
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) state_d = trap_c ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (dmem_req_ready) state_d = re_q ? S_WAIT_RESP : S_DONE;
      end
      S_WAIT_RESP: begin
        stall = 1'b1;
        if (dmem_resp_valid) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      re_q           <= 1'b0;
      funct3_q       <= 3'd0;
      off_q          <= 2'd0;
      done           <= 1'b0;
      load_data      <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wmask <= 4'b0000;
      dmem_req_wdata <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == S_DONE);
      if (accept_c) begin
        re_q      <= req_re;
        funct3_q  <= req_funct3;
        off_q     <= off;
        load_data <= '0;
        // Trapped accesses never reach the cache, so the request fields stay put
        if (!trap_c) begin
          dmem_req_valid <= 1'b1;
          dmem_req_addr  <= req_addr[ADDR_W-1:2];
          dmem_req_wmask <= mask_c;
          dmem_req_wdata <= wdata_c;
        end
      end
      if ((state_q == S_REQ) && dmem_req_ready) dmem_req_valid <= 1'b0;
      if ((state_q == S_WAIT_RESP) && dmem_resp_valid)
        load_data <= load_ext(dmem_resp_data, funct3_q, off_q);
    end
  end

`ifdef MW_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= accept_c && trap_c;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mw_dmem_sequencer.sv
// Randomized bench for mw_dmem_sequencer against a transaction-level timing and data model.
module tb_mw_dmem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_re;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misalign;
  logic [31:0] load_data;
  logic        dmem_req_valid, dmem_req_ready;
  logic [29:0] dmem_req_addr;
  logic [3:0]  dmem_req_wmask;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mw_dmem_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_re(req_re), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .load_data(load_data), .misalign(misalign),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wmask(dmem_req_wmask),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference rules
  function automatic bit exp_trap(input bit re, input logic [2:0] f3, input logic [1:0] off);
`ifdef MW_MISALIGN_TRAP_EN
    if (f3 == 3'd2) return off != 2'd0;
    if (f3 == 3'd1 || (re && f3 == 3'd5)) return off[0];
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_mask(input bit re, input logic [2:0] f3, input logic [1:0] off);
    int o = int'(off);
    if (re) return 4'd0;
    case (f3)
      3'd0:    return 4'((1 << o) & 15);
      3'd1:    return 4'((3 << (o & 2)) & 15);
      3'd2:    return 4'hF;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return 32'(wd[7:0]) * 32'h0101_0101;
      3'd1:    return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int o = int'(off);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'd0;
    endcase
  endfunction

  // One full access from its IDLE cycle through DONE, checked cycle by cycle
  task automatic run_op(input bit re, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdy, input int rsp,
                        input logic [31:0] rdata, input bit junk);
    logic [1:0]  off;
    bit          trap;
    logic [3:0]  m;
    off  = addr[1:0];
    trap = exp_trap(re, f3, off);
    m    = exp_mask(re, f3, off);
    @(posedge clk); #1;
    req_valid = 1'b1; req_re = re; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    #2;
    chk("idle_stall", stall, 1);
    chk("idle_done", done, 0);
    chk("idle_reqv", dmem_req_valid, 0);
    if (!trap) begin
      for (int k = 0; k <= rdy; k++) begin
        @(posedge clk); #1;
        dmem_req_ready  = (k == rdy);
        dmem_resp_valid = junk && (k == rdy);
        dmem_resp_data  = 32'hDEAD_BEEF;
        #2;
        chk("req_valid", dmem_req_valid, 1);
        chk("req_stall", stall, 1);
        chk("req_done", done, 0);
        chk("req_addr", dmem_req_addr, addr >> 2);
        chk("req_mask", dmem_req_wmask, m);
        if (m != 4'd0) chk("req_wdata", dmem_req_wdata, exp_wdata(f3, wd));
      end
      if (re) begin
        for (int j = 1; j <= rsp; j++) begin
          @(posedge clk); #1;
          dmem_req_ready  = 1'b0;
          dmem_resp_valid = (j == rsp);
          dmem_resp_data  = (j == rsp) ? rdata : $urandom;
          #2;
          chk("wait_stall", stall, 1);
          chk("wait_done", done, 0);
          chk("wait_reqv", dmem_req_valid, 0);
        end
      end
    end
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    #2;
    chk("done_pulse", done, 1);
    chk("done_stall", stall, 0);
    chk("done_misalign", misalign, trap);
    chk("done_reqv", dmem_req_valid, 0);
    if (re || trap) chk("load_data", load_data, trap ? 32'd0 : exp_load(f3, off, rdata));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
      #2;
      chk("gap_stall", stall, 0);
      chk("gap_done", done, 0);
      chk("gap_reqv", dmem_req_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_re = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_reqv", dmem_req_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_load", load_data, 0);
    chk("rst_addr", dmem_req_addr, 0);
    chk("rst_mask", dmem_req_wmask, 0);
    chk("rst_stall", stall, 0);

    // Directed cases
    run_op(1'b0, 3'd0, 32'h0000_1003, 32'h0000_00AB, 0, 1, 32'd0, 1'b0);
    idle_cycles(1);
    run_op(1'b1, 3'd0, 32'h0000_2002, 32'd0, 0, 1, 32'h12F4_5678, 1'b0);
    run_op(1'b1, 3'd4, 32'h0000_2002, 32'd0, 0, 1, 32'h12F4_5678, 1'b1);
    run_op(1'b0, 3'd2, 32'h0000_4000, 32'hCAFE_F00D, 5, 1, 32'd0, 1'b0);
    run_op(1'b1, 3'd1, 32'h0000_3001, 32'd0, 0, 1, 32'hBEEF_1234, 1'b0);
    run_op(1'b1, 3'd2, 32'h0000_5004, 32'd0, 0, 1, 32'h8765_4321, 1'b0);
    run_op(1'b0, 3'd2, 32'h0000_5008, 32'h0BAD_CAFE, 0, 1, 32'd0, 1'b0);
    run_op(1'b0, 3'd1, 32'h0000_600E, 32'h0000_9ABC, 2, 1, 32'd0, 1'b0);
    run_op(1'b0, 3'd3, 32'h0000_7000, 32'h1111_2222, 0, 1, 32'd0, 1'b0);
    run_op(1'b1, 3'd5, 32'h0000_8002, 32'd0, 1, 3, 32'h9234_5678, 1'b0);
    idle_cycles(2);

    // Reset while waiting on a load response
    @(posedge clk); #1;
    req_valid = 1'b1; req_re = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0000_9000;
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("rstw_reqv", dmem_req_valid, 0);
    chk("rstw_done", done, 0);
    chk("rstw_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dmem_resp_valid = 1'b1; dmem_resp_data = 32'h5555_AAAA;
      #2;
      chk("rstw_late_done", done, 0);
      chk("rstw_late_reqv", dmem_req_valid, 0);
    end
    @(posedge clk); #1 dmem_resp_valid = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit          re;
      logic [2:0]  f3;
      re = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      run_op(re, f3, $urandom, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
